ahb_interconnect: RTL and testbench
===================================

Name: ahb_interconnect

Overview:
- Second-generation single-master AHB-Lite decoder/multiplexor with a registered data-phase select, so slave responses are routed by the slave that owns the current data phase rather than the current address.
- Adds a built-in default slave that gives the spec-compliant two-cycle ERROR response to unmapped NONSEQ/SEQ accesses.
- Resolves overlapping address ranges by fixed priority.
- Sits between the RISC-V core's AHB-Lite master port and the memory/peripheral slaves.

Parameters:
- NUM_SLAVES, 8, number of slave ports (1..16).
- DATA_WIDTH, 32, HWDATA/HRDATA width.
- ADDR_WIDTH, 32, HADDR width.
- SLAVE_BASE_ADDR, {ADDR_WIDTH-bit 0x0000,0x1000,...,0x7000}, packed base addresses; slave i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- SLAVE_LAST_ADDR, {0x0FFF,...,0x7FFF}, packed inclusive last addresses, same packing.
- SEL_BYPASS, 0, when 1 slave i additionally requires m_hsel_in == i.
- TIMEOUT_CYCLES, 255, data-phase wait limit; used only with AHB_TIMEOUT_EN.

Ports:
- hclk_in  in  1  bus clock; all state on rising edge.
- hrst_in  in  1  reset, asynchronous, active-high.
- m_haddr_in  in  ADDR_WIDTH  master address.
- m_hwdata_in  in  DATA_WIDTH  master write data.
- m_hrdata_out  out  DATA_WIDTH  read data to master.
- m_htrans_in  in  2  transfer type.
- m_hsize_in  in  3  size.
- m_hburst_in  in  3  burst.
- m_hprot_in  in  4  protection.
- m_hsel_in  in  max(1,clog2(NUM_SLAVES))  explicit slave index, used when SEL_BYPASS=1.
- m_hwrite_in  in  1  write.
- m_hmastlock_in  in  1  locked.
- m_hready_out  out  1  HREADY to master.
- m_hresp_out  out  1  HRESP to master (0 OKAY, 1 ERROR).
- s_haddr_out  out  NUM_SLAVES*ADDR_WIDTH  address, broadcast.
- s_hwdata_out  out  NUM_SLAVES*DATA_WIDTH  write data, broadcast.
- s_hrdata_in  in  NUM_SLAVES*DATA_WIDTH  slave read data.
- s_htrans_out  out  NUM_SLAVES*2  m_htrans_in to the selected slave, IDLE (00) to all others.
- s_hsize_out, s_hburst_out, s_hprot_out  out  NUM_SLAVES*3/3/4  broadcast control.
- s_hwrite_out, s_hmastlock_out  out  NUM_SLAVES  broadcast.
- s_hsel_out  out  NUM_SLAVES  address-phase one-hot select.
- s_hresp_in, s_hready_in  in  NUM_SLAVES  slave responses.
- s_hready_out  out  NUM_SLAVES  HREADY to every slave, equal to m_hready_out.

Behaviour:
- Address decode (combinational):
  - hit[i] = base[i] <= haddr <= last[i], ANDed with (m_hsel_in == i) when SEL_BYPASS=1.
  - Lowest-index hit wins; s_hsel_out is one-hot or zero.
  - unmapped = no hit.
- Data-phase select register dsel[NUM_SLAVES:0]; bit NUM_SLAVES is the default slave.
  - Reset value 0.
  - When m_hready_out=1: dsel <= {unmapped & htrans[1], s_hsel_out}.
  - When m_hready_out=0: dsel holds.
- Response mux (combinational on dsel):
  - dsel[i] set: m_hready_out=s_hready_in[i], m_hresp_out=s_hresp_in[i], m_hrdata_out=s_hrdata_in[i].
  - dsel default bit set: outputs come from the default-slave FSM, hrdata=0.
  - dsel all zero (after reset, or IDLE/BUSY to unmapped): hready=1, hresp=0, hrdata=0.
- Reset values of outputs: m_hready_out=1, m_hresp_out=0, m_hrdata_out=0. s_* outputs are combinational from the master inputs.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2; reset DS_IDLE.
  - DS_IDLE -> DS_ERR1 when m_hready_out=1 & unmapped & htrans[1].
  - DS_ERR1: hready=0, hresp=1; always -> DS_ERR2.
  - DS_ERR2: hready=1, hresp=1; -> DS_ERR1 if a new unmapped NONSEQ/SEQ is presented this cycle, else -> DS_IDLE.
- IDLE/BUSY to a mapped slave is forwarded; the slave must return zero-wait OKAY per AHB-Lite.
- Back-to-back transfers to different slaves: the address for slave B is decoded while slave A's data phase is still returning; A's wait states hold dsel on A.
- Reset asserted mid-transfer: dsel and FSM clear asynchronously; the master sees hready=1/OKAY immediately.

Optional Feature:
- Macro AHB_TIMEOUT_EN.
- Defined:
  - A wait counter increments each cycle the selected data-phase slave drives hready low, and clears on hready high or when dsel changes.
  - When the counter reaches TIMEOUT_CYCLES, the block forces DS_ERR1 (two-cycle ERROR to master).
  - dsel is redirected to the default slave, and the stalled slave's later response is ignored.
- Undefined: no counter; wait states are unbounded.

Decomposition:
- Package ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, default-slave state encoding.
- Sub-module ahb_default_slave: owns the ERR FSM and, when AHB_TIMEOUT_EN is defined, the timeout counter.

Test Plan:
- NONSEQ read 0x1004, slave1 returns 0xDEADBEEF after 2 wait states -> s_hsel_out=0x02; m_hready_out low 2 cycles; then hrdata=0xDEADBEEF, hresp=0.
- Pipelined NONSEQ to 0x0000 then 0x2000, slave0 stalls 3 cycles -> response routed from slave0 until it completes, then slave2; no data crossover.
- NONSEQ to 0x9000 (unmapped) -> one cycle hready=0/hresp=1, next cycle hready=1/hresp=1, then OKAY; IDLE to 0x9000 -> zero-wait OKAY.
- Overlap map (slave1 0x1000-0x1FFF, slave3 0x1800-0x1FFF), access 0x1800 -> s_hsel_out=0x02 only.
- Reset pulse while slave2 holds hready low -> immediately m_hready_out=1, hresp=0, hrdata=0, FSM DS_IDLE.
- With AHB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave5 never readies -> after 4 wait cycles a two-cycle ERROR; the next transfer proceeds normally.

Source files
------------

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and default-slave state type
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  // NONSEQ and SEQ carry a data phase; IDLE and BUSY do not.
  function automatic logic is_active(input logic [1:0] htrans);
    logic act;
    act = 1'b0;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - two-cycle ERROR responder for unmapped or timed-out data phases
// Optional wait-state timeout enabled by AHB_TIMEOUT_EN.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic hready,
  input  logic err_req,
  input  logic stall,
  output logic ds_hready,
  output logic ds_hresp,
  output logic timeout
);

  ds_state_t state;
  ds_state_t state_next;

`ifdef AHB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // Fires on the last permitted wait cycle so the ERROR follows immediately.
  assign timeout = stall && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Count consecutive cycles the owning slave holds the bus in wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!stall || timeout) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_stall;
  assign unused_stall = stall ^ (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

  // First ERROR cycle stalls the master, second one releases it.
  assign ds_hready = (state != DS_ERR1);
  assign ds_hresp  = (state == DS_ERR1 || state == DS_ERR2) ? HRESP_ERROR : HRESP_OKAY;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the ERROR sequence.
  always_comb begin
    state_next = state;
    case (state)
      DS_IDLE: if (timeout || (hready && err_req)) state_next = DS_ERR1;
      DS_ERR1: state_next = DS_ERR2;
      DS_ERR2: state_next = (hready && err_req) ? DS_ERR1 : DS_IDLE;
      default: state_next = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_interconnect.sv
// rtl/ahb_interconnect.sv - single-master AHB-Lite decoder and data-phase response multiplexor
// Optional data-phase timeout enabled by AHB_TIMEOUT_EN.
module ahb_interconnect
  import ahb_pkg::*;
#(
  parameter int NUM_SLAVES = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE_ADDR = {
    32'h0000_7000, 32'h0000_6000, 32'h0000_5000, 32'h0000_4000,
    32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_LAST_ADDR = {
    32'h0000_7FFF, 32'h0000_6FFF, 32'h0000_5FFF, 32'h0000_4FFF,
    32'h0000_3FFF, 32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF},
  parameter bit SEL_BYPASS = 1'b0,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                             hclk_in,
  input  logic                             hrst_in,
  input  logic [ADDR_WIDTH-1:0]            m_haddr_in,
  input  logic [DATA_WIDTH-1:0]            m_hwdata_in,
  output logic [DATA_WIDTH-1:0]            m_hrdata_out,
  input  logic [1:0]                       m_htrans_in,
  input  logic [2:0]                       m_hsize_in,
  input  logic [2:0]                       m_hburst_in,
  input  logic [3:0]                       m_hprot_in,
  input  logic [SEL_W-1:0]                 m_hsel_in,
  input  logic                             m_hwrite_in,
  input  logic                             m_hmastlock_in,
  output logic                             m_hready_out,
  output logic                             m_hresp_out,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_haddr_out,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hwdata_out,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_hrdata_in,
  output logic [NUM_SLAVES*2-1:0]          s_htrans_out,
  output logic [NUM_SLAVES*3-1:0]          s_hsize_out,
  output logic [NUM_SLAVES*3-1:0]          s_hburst_out,
  output logic [NUM_SLAVES*4-1:0]          s_hprot_out,
  output logic [NUM_SLAVES-1:0]            s_hwrite_out,
  output logic [NUM_SLAVES-1:0]            s_hmastlock_out,
  output logic [NUM_SLAVES-1:0]            s_hsel_out,
  input  logic [NUM_SLAVES-1:0]            s_hresp_in,
  input  logic [NUM_SLAVES-1:0]            s_hready_in,
  output logic [NUM_SLAVES-1:0]            s_hready_out
);

  logic [NUM_SLAVES-1:0] hsel;
  logic                  unmapped;
  logic                  err_req;
  logic [NUM_SLAVES:0]   dsel;
  logic                  stall;
  logic                  timeout;
  logic                  ds_hready;
  logic                  ds_hresp;

  // Address decode; walking downwards lets the lowest-index hit win overlaps.
  always_comb begin
    hsel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_haddr_in >= SLAVE_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (m_haddr_in <= SLAVE_LAST_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (!SEL_BYPASS || (m_hsel_in == SEL_W'(i)))) begin
        hsel    = '0;
        hsel[i] = 1'b1;
      end
    end
  end

  assign unmapped   = ~|hsel;
  assign err_req    = unmapped & is_active(m_htrans_in);
  assign s_hsel_out = hsel;

  // Only the selected slave sees the real transfer type; everyone else sees IDLE.
  always_comb begin
    s_htrans_out = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_htrans_out[2*i +: 2] = hsel[i] ? m_htrans_in : HTRANS_IDLE;
    end
  end

  assign s_haddr_out     = {NUM_SLAVES{m_haddr_in}};
  assign s_hwdata_out    = {NUM_SLAVES{m_hwdata_in}};
  assign s_hsize_out     = {NUM_SLAVES{m_hsize_in}};
  assign s_hburst_out    = {NUM_SLAVES{m_hburst_in}};
  assign s_hprot_out     = {NUM_SLAVES{m_hprot_in}};
  assign s_hwrite_out    = {NUM_SLAVES{m_hwrite_in}};
  assign s_hmastlock_out = {NUM_SLAVES{m_hmastlock_in}};
  assign s_hready_out    = {NUM_SLAVES{m_hready_out}};

  assign stall = |(dsel[NUM_SLAVES-1:0] & ~s_hready_in);

  // Data-phase owner: advances with the address phase, snaps to the default slave on timeout.
  always_ff @(posedge hclk_in or posedge hrst_in) begin
    if (hrst_in) begin
      dsel <= '0;
    end else if (timeout) begin
      dsel <= {1'b1, {NUM_SLAVES{1'b0}}};
    end else if (m_hready_out) begin
      dsel <= {err_req, hsel};
    end
  end

  // Route the response of whichever slave owns the current data phase.
  always_comb begin
    m_hready_out = 1'b1;
    m_hresp_out  = HRESP_OKAY;
    m_hrdata_out = '0;
    if (dsel[NUM_SLAVES]) begin
      m_hready_out = ds_hready;
      m_hresp_out  = ds_hresp;
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel[i]) begin
        m_hready_out = s_hready_in[i];
        m_hresp_out  = s_hresp_in[i];
        m_hrdata_out = s_hrdata_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  ahb_default_slave #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_default_slave (
    .clk      (hclk_in),
    .rst      (hrst_in),
    .hready   (m_hready_out),
    .err_req  (err_req),
    .stall    (stall),
    .ds_hready(ds_hready),
    .ds_hresp (ds_hresp),
    .timeout  (timeout)
  );

endmodule

// File: tb/tb_ahb_interconnect.sv
// tb/tb_ahb_interconnect.sv - scoreboard bench for ahb_interconnect
module tb_ahb_interconnect;
  import ahb_pkg::*;

  localparam int NS = 8;

  logic          clk;
  logic          rst;
  logic [31:0]   m_haddr;
  logic [31:0]   m_hwdata;
  logic [31:0]   m_hrdata;
  logic [1:0]    m_htrans;
  logic [2:0]    m_hsize;
  logic [2:0]    m_hburst;
  logic [3:0]    m_hprot;
  logic [2:0]    m_hsel;
  logic          m_hwrite;
  logic          m_hmastlock;
  logic          m_hready;
  logic          m_hresp;
  logic [NS*32-1:0] s_haddr;
  logic [NS*32-1:0] s_hwdata;
  logic [NS*32-1:0] s_hrdata;
  logic [NS*2-1:0]  s_htrans;
  logic [NS*3-1:0]  s_hsize;
  logic [NS*3-1:0]  s_hburst;
  logic [NS*4-1:0]  s_hprot;
  logic [NS-1:0]    s_hwrite;
  logic [NS-1:0]    s_hmastlock;
  logic [NS-1:0]    s_hsel;
  logic [NS-1:0]    s_hresp;
  logic [NS-1:0]    s_hready_in;
  logic [NS-1:0]    s_hready_out;

  ahb_interconnect #(
    .NUM_SLAVES     (NS),
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .SLAVE_BASE_ADDR({32'h7000, 32'h6000, 32'h5000, 32'h4000,
                      32'h1800, 32'h2000, 32'h1000, 32'h0000}),
    .SLAVE_LAST_ADDR({32'h7FFF, 32'h6FFF, 32'h5FFF, 32'h4FFF,
                      32'h1FFF, 32'h2FFF, 32'h1FFF, 32'h0FFF}),
    .SEL_BYPASS     (1'b0),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .hclk_in        (clk),
    .hrst_in        (rst),
    .m_haddr_in     (m_haddr),
    .m_hwdata_in    (m_hwdata),
    .m_hrdata_out   (m_hrdata),
    .m_htrans_in    (m_htrans),
    .m_hsize_in     (m_hsize),
    .m_hburst_in    (m_hburst),
    .m_hprot_in     (m_hprot),
    .m_hsel_in      (m_hsel),
    .m_hwrite_in    (m_hwrite),
    .m_hmastlock_in (m_hmastlock),
    .m_hready_out   (m_hready),
    .m_hresp_out    (m_hresp),
    .s_haddr_out    (s_haddr),
    .s_hwdata_out   (s_hwdata),
    .s_hrdata_in    (s_hrdata),
    .s_htrans_out   (s_htrans),
    .s_hsize_out    (s_hsize),
    .s_hburst_out   (s_hburst),
    .s_hprot_out    (s_hprot),
    .s_hwrite_out   (s_hwrite),
    .s_hmastlock_out(s_hmastlock),
    .s_hsel_out     (s_hsel),
    .s_hresp_in     (s_hresp),
    .s_hready_in    (s_hready_in),
    .s_hready_out   (s_hready_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Behavioural slaves: programmable wait states and a fixed read word each.
  int          wait_cfg  [NS];
  logic [31:0] rdata_cfg [NS];
  int          wcnt      [NS];
  logic [NS-1:0] act;

  always_comb begin
    s_hready_in = '1;
    s_hrdata    = '0;
    for (int i = 0; i < NS; i++) begin
      s_hready_in[i] = !act[i] || (wcnt[i] == 0);
      if (act[i] && wcnt[i] == 0) s_hrdata[i*32 +: 32] = rdata_cfg[i];
    end
  end

  assign s_hresp = '0;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NS; i++) begin
      if (rst) begin
        act[i]  <= 1'b0;
        wcnt[i] <= 0;
      end else if (act[i] && wcnt[i] != 0) begin
        wcnt[i] <= wcnt[i] - 1;
      end else if (m_hready) begin
        act[i]  <= s_hsel[i] & s_htrans[2*i+1];
        wcnt[i] <= wait_cfg[i];
      end
    end
  end

  // Scoreboard of expected data-phase results, in issue order.
  typedef struct {
    logic        resp;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic dp_valid;
  int   dp_waits;
  logic dp_last_resp;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      dp_valid     = 1'b0;
      dp_waits     = 0;
      dp_last_resp = 1'b0;
    end else if (dp_valid && !m_hready) begin
      dp_waits++;
      dp_last_resp = m_hresp;
    end else if (m_hready) begin
      if (dp_valid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("resp", 32'(m_hresp), 32'(e.resp));
          check("rdata", m_hrdata, e.data);
          check("waits", 32'(dp_waits), 32'(e.waits));
          if (e.waits > 0) check("wait_resp", 32'(dp_last_resp), 32'(e.resp));
        end
      end
      dp_valid = m_htrans[1];
      dp_waits = 0;
    end
  end

  task automatic issue(input logic [31:0] addr, input logic [1:0] trans, input logic wr,
                       input logic [7:0] exp_sel, input logic exp_resp,
                       input logic [31:0] exp_data, input int exp_waits);
    logic [15:0] exp_trans;
    logic [31:0] wdata;
    int n;
    wdata    = $urandom;
    m_haddr  = addr;
    m_htrans = trans;
    m_hwrite = wr;
    m_hwdata = wdata;
    if (trans[1]) sb.push_back('{exp_resp, exp_data, exp_waits});
    @(negedge clk);
    check("hsel", 32'(s_hsel), 32'(exp_sel));
    exp_trans = '0;
    for (int i = 0; i < NS; i++) if (exp_sel[i]) exp_trans[2*i +: 2] = trans;
    check("htrans_route", 32'(s_htrans), 32'(exp_trans));
    check("haddr_bcast", s_haddr[7*32 +: 32], addr);
    check("hwdata_bcast", s_hwdata[3*32 +: 32], wdata);
    n = 0;
    while (!m_hready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_htrans = HTRANS_IDLE;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || dp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m_haddr = '0; m_hwdata = '0; m_htrans = HTRANS_IDLE; m_hsize = 3'd2;
    m_hburst = '0; m_hprot = 4'h3; m_hsel = '0; m_hwrite = 1'b0; m_hmastlock = 1'b0;
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i]  = 0;
      rdata_cfg[i] = 32'hA000_0000 | (32'(i) << 8) | 32'(i);
    end
    rdata_cfg[1] = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    check("reset_hready", 32'(m_hready), 32'd1);
    check("reset_hresp", 32'(m_hresp), 32'd0);
    check("reset_hrdata", m_hrdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Read from slave1 with two wait states.
    wait_cfg[1] = 2;
    issue(32'h1004, HTRANS_NONSEQ, 1'b0, 8'h02, 1'b0, 32'hDEAD_BEEF, 2);
    idle();
    drain();
    wait_cfg[1] = 0;

    // IDLE to an unmapped address: zero-wait OKAY.
    m_haddr = 32'h9000;
    m_htrans = HTRANS_IDLE;
    @(negedge clk);
    check("idle_unmapped_hsel", 32'(s_hsel), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_unmapped_hready", 32'(m_hready), 32'd1);
    check("idle_unmapped_hresp", 32'(m_hresp), 32'd0);
    @(posedge clk);
    #1;

    // NONSEQ to an unmapped address: two-cycle ERROR, then OKAY.
    issue(32'h9000, HTRANS_NONSEQ, 1'b0, 8'h00, 1'b1, 32'd0, 1);
    idle();
    drain();
    @(negedge clk);
    check("after_err_hready", 32'(m_hready), 32'd1);
    check("after_err_hresp", 32'(m_hresp), 32'd0);
    @(posedge clk);
    #1;

    // Overlap: slave1 and slave3 both cover 0x1800; slave1 wins.
    rdata_cfg[1] = 32'h1111_1111;
    issue(32'h1800, HTRANS_NONSEQ, 1'b0, 8'h02, 1'b0, 32'h1111_1111, 0);
    issue(32'h1FFC, HTRANS_SEQ, 1'b0, 8'h02, 1'b0, 32'h1111_1111, 0);
    idle();
    drain();

    // Pipelined: slave0 stalls three cycles while slave2's address waits.
    wait_cfg[0] = 3;
    issue(32'h0000, HTRANS_NONSEQ, 1'b0, 8'h01, 1'b0, rdata_cfg[0], 3);
    issue(32'h2000, HTRANS_NONSEQ, 1'b0, 8'h04, 1'b0, rdata_cfg[2], 0);
    issue(32'h7010, HTRANS_NONSEQ, 1'b1, 8'h80, 1'b0, rdata_cfg[7], 0);
    issue(32'h9000, HTRANS_NONSEQ, 1'b0, 8'h00, 1'b1, 32'd0, 1);
    issue(32'h4000, HTRANS_NONSEQ, 1'b0, 8'h10, 1'b0, rdata_cfg[4], 0);
    idle();
    drain();
    wait_cfg[0] = 0;

    // Reset while slave2 holds the bus in wait.
    wait_cfg[2] = 1000;
    issue(32'h2040, HTRANS_NONSEQ, 1'b0, 8'h04, 1'b0, rdata_cfg[2], 0);
    idle();
    @(negedge clk);
    check("stall_before_rst", 32'(m_hready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rst_hready", 32'(m_hready), 32'd1);
    check("rst_hresp", 32'(m_hresp), 32'd0);
    check("rst_hrdata", m_hrdata, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cfg[2] = 0;
    issue(32'h2000, HTRANS_NONSEQ, 1'b0, 8'h04, 1'b0, rdata_cfg[2], 0);
    idle();
    drain();

`ifdef AHB_TIMEOUT_EN
    // Slave5 never readies: four wait cycles, then ERROR; next transfer is normal.
    wait_cfg[5] = 1000;
    issue(32'h5000, HTRANS_NONSEQ, 1'b0, 8'h20, 1'b1, 32'd0, 5);
    issue(32'h0000, HTRANS_NONSEQ, 1'b0, 8'h01, 1'b0, rdata_cfg[0], 0);
    idle();
    drain();
`endif

    drain();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
